exe_hazard_controller: RTL and testbench
========================================

EXE_HAZARD_CONTROLLER -- requirements
Module: exe_hazard_controller

Interface
REQ-001 The block SHALL expose the following ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  reset; asynchronous, active-low.
- forward_en  in  1  1 enables forwarding.
- id_src1, id_src2  in  4  ID-stage source registers.
- id_two_src  in  1  id_src2 is a real source.
- exe_src1, exe_src2  in  4  EXE-stage source registers.
- exe_wb_en  in  1  EXE instruction writes back.
- exe_mem_r_en  in  1  EXE instruction is a load.
- exe_dest  in  4  EXE destination register.
- branch_taken  in  1  EXE branch taken.
- mem_wb_en  in  1  MEM instruction writes back.
- mem_dest  in  4  MEM destination register.
- mem_req  in  1  MEM stage is accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- wb_wb_en  in  1  WB instruction writes back.
- wb_dest  in  4  WB destination register.
- alu_src1_mux_sel, alu_src2_mux_sel  out  2  00 = register value, 01 = MEM result, 10 = WB result.
- freeze_front  out  1  hold PC and IF/ID.
- bubble_exe  out  1  load NOP into ID/EXE.
- flush  out  1  clear IF/ID and ID/EXE.
- freeze_all  out  1  hold every pipeline register.
- stall_cycles  out  16  saturating count of freeze_all cycles.
- flush_count  out  8  saturating count of flushes.

Function
REQ-002 Forwarding selects SHALL be combinational and independent of the state machine.
- Each select is 01 if forward_en, mem_wb_en and mem_dest equals the source register.
- Otherwise it is 10 if forward_en, wb_wb_en and wb_dest equals the source register.
- Otherwise it is 00.
- MEM has priority over WB.
REQ-003 The hazard condition SHALL be computed over id_src1, and over id_src2 only when id_two_src is 1.
- forward_en = 1: hazard when exe_mem_r_en and the source equals exe_dest.
- forward_en = 0: hazard when (exe_wb_en and the source equals exe_dest) or (mem_wb_en and the source equals mem_dest).
REQ-004 The state machine SHALL have two states, RUN and MEM_WAIT, and reset to RUN.
REQ-005 State transitions SHALL be:
- RUN to MEM_WAIT when mem_req=1 and mem_ready=0.
- MEM_WAIT to RUN on the cycle mem_ready=1.
- All other cases hold the current state.
REQ-006 freeze_all SHALL be 1 while in MEM_WAIT, and also in RUN when mem_req=1 and mem_ready=0 (same-cycle entry); it is 0 on the cycle mem_ready=1.
REQ-007 Priority SHALL be freeze_all, then flush, then hazard stall.
- While freeze_all=1: flush=0, freeze_front=0, bubble_exe=0.
REQ-008 When branch_taken=1 while freeze_all=1, a pending_flush flag SHALL be set.
- flush is asserted for exactly one cycle on the first cycle freeze_all=0.
- The flag is then cleared.
- Several branch_taken cycles during one freeze SHALL produce a single flush.
REQ-009 When freeze_all=0, flush SHALL equal branch_taken OR pending_flush.
- When flush=1, freeze_front=0 and bubble_exe=0.
REQ-010 When freeze_all=0 and flush=0, freeze_front and bubble_exe SHALL both equal the hazard condition.
- Repeated hazards stall on every cycle without a limit.
REQ-011 stall_cycles SHALL increment by 1 on each clock edge where freeze_all=1 and hold at 16'hFFFF.
REQ-012 flush_count SHALL increment by 1 on each clock edge where flush=1 and hold at 8'hFF.
REQ-013 Register 0 SHALL receive no special treatment: a match on register 0 counts as a match.

Reset
REQ-014 While rst=0, independent of clk, the block SHALL hold:
- state = RUN, pending_flush = 0, stall_cycles = 0, flush_count = 0.
- Sequential outputs low; combinational outputs follow from state RUN.
REQ-015 Reset asserted during MEM_WAIT SHALL abandon the wait and discard any pending flush.
- Behaviour after release is purely combinational from RUN.

Structure
REQ-016 The shared constants package SHALL hold:
- state encodings (RUN=0, MEM_WAIT=1);
- forwarding-select encodings;
- the register-index width (4).
REQ-017 Forwarding logic SHALL be one sub-module, forwarding_unit, instantiated once per ALU source.
- The state machine, priority logic and counters stay in the top module.

Verification
REQ-018 Forwarding priority: forward_en=1, exe_src1=3, mem_dest=3 and wb_dest=3 with both write-enables set -> alu_src1_mux_sel=01; with mem_wb_en=0 -> 10; with forward_en=0 -> 00.
REQ-019 Load-use stall: exe_mem_r_en=1, exe_dest=5, id_src2=5 -> freeze_front=1 and bubble_exe=1 when id_two_src=1; both 0 when id_two_src=0.
REQ-020 Memory wait with branch: mem_req=1, mem_ready=0 for 4 cycles, branch_taken=1 on the 2nd cycle -> freeze_all=1 for 4 cycles, flush=0 during the wait, flush=1 for exactly 1 cycle after mem_ready, stall_cycles=4, flush_count=1.
REQ-021 Saturation: 70000 freeze_all cycles -> stall_cycles=16'hFFFF; 300 flushes -> flush_count=8'hFF.
REQ-022 Reset mid-wait: rst=0 during MEM_WAIT with pending_flush set -> state RUN, no flush after release, counters 0.
REQ-023 No-forward hazard: forward_en=0, mem_wb_en=1, mem_dest=7, id_src1=7 -> freeze_front=1; with branch_taken=1 in the same cycle -> flush=1 and freeze_front=0.

Source files
------------

// File: rtl/exe_hazard_controller_pkg.sv
// Shared constants for the EXE hazard controller: state and forwarding-select
// encodings, register-index width and the per-source hazard helper.
package exe_hazard_controller_pkg;

    localparam int REG_W = 4;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    // With forwarding only a load in EXE stalls. Without it, any pending write
    // in EXE or MEM does. Register 0 is an ordinary register here.
    function automatic logic src_hazard(
        input logic             forward_en,
        input logic [REG_W-1:0] src,
        input logic             exe_wb_en,
        input logic             exe_mem_r_en,
        input logic [REG_W-1:0] exe_dest,
        input logic             mem_wb_en,
        input logic [REG_W-1:0] mem_dest
    );
        if (forward_en)
            return exe_mem_r_en && (src == exe_dest);
        else
            return (exe_wb_en && (src == exe_dest)) || (mem_wb_en && (src == mem_dest));
    endfunction

endpackage

// File: rtl/exe_hazard_controller_forwarding_unit.sv
// Forwarding select for one ALU source. The MEM result is newer than the WB
// result, so MEM wins when both match.
module forwarding_unit
    import exe_hazard_controller_pkg::*;
(
    input  logic             forward_en,
    input  logic [REG_W-1:0] src,
    input  logic             mem_wb_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             wb_wb_en,
    input  logic [REG_W-1:0] wb_dest,
    output logic [1:0]       sel
);

    // NOTE: sel is given a value before any branch so that no path through
    // this block leaves it unassigned and infers a latch.
    always_comb begin
        sel = FWD_REG;
        if (forward_en && mem_wb_en && (mem_dest == src))
            sel = FWD_MEM;
        else if (forward_en && wb_wb_en && (wb_dest == src))
            sel = FWD_WB;
    end

endmodule

// File: rtl/exe_hazard_controller.sv
// EXE-stage hazard controller: operand forwarding, load-use/RAW stalls, branch
// flushes and whole-pipeline freezes while data memory is busy.
module exe_hazard_controller
    import exe_hazard_controller_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             forward_en,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] exe_src1,
    input  logic [REG_W-1:0] exe_src2,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             branch_taken,
    input  logic             mem_wb_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             wb_wb_en,
    input  logic [REG_W-1:0] wb_dest,
    output logic [1:0]       alu_src1_mux_sel,
    output logic [1:0]       alu_src2_mux_sel,
    output logic             freeze_front,
    output logic             bubble_exe,
    output logic             flush,
    output logic             freeze_all,
    output logic [15:0]      stall_cycles,
    output logic [7:0]       flush_count
);

    localparam logic [15:0] STALL_MAX = 16'hFFFF;
    localparam logic [7:0]  FLUSH_MAX = 8'hFF;

    state_t state;
    logic   pending_flush;
    logic   hazard;

    forwarding_unit u_fwd_src1 (
        .forward_en (forward_en),
        .src        (exe_src1),
        .mem_wb_en  (mem_wb_en),
        .mem_dest   (mem_dest),
        .wb_wb_en   (wb_wb_en),
        .wb_dest    (wb_dest),
        .sel        (alu_src1_mux_sel)
    );

    forwarding_unit u_fwd_src2 (
        .forward_en (forward_en),
        .src        (exe_src2),
        .mem_wb_en  (mem_wb_en),
        .mem_dest   (mem_dest),
        .wb_wb_en   (wb_wb_en),
        .wb_dest    (wb_dest),
        .sel        (alu_src2_mux_sel)
    );

    always_comb begin
        hazard = src_hazard(forward_en, id_src1, exe_wb_en, exe_mem_r_en,
                            exe_dest, mem_wb_en, mem_dest)
              || (id_two_src && src_hazard(forward_en, id_src2, exe_wb_en,
                                           exe_mem_r_en, exe_dest, mem_wb_en, mem_dest));
    end

    // The freeze starts in the same cycle the memory stall is seen, before the
    // state register has caught up, and drops on the cycle the memory is ready.
    always_comb begin
        freeze_all   = !mem_ready && ((state == MEM_WAIT) || mem_req);
        flush        = !freeze_all && (branch_taken || pending_flush);
        freeze_front = !freeze_all && !flush && hazard;
        bubble_exe   = !freeze_all && !flush && hazard;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RUN;
            pending_flush <= 1'b0;
            stall_cycles  <= '0;
            flush_count   <= '0;
        end else begin
            if (state == RUN) begin
                if (mem_req && !mem_ready)
                    state <= MEM_WAIT;
            end else if (mem_ready) begin
                state <= RUN;
            end

            // A taken branch during a freeze is remembered and becomes one flush.
            if (freeze_all && branch_taken)
                pending_flush <= 1'b1;
            else if (!freeze_all)
                pending_flush <= 1'b0;

            if (freeze_all && (stall_cycles != STALL_MAX))
                stall_cycles <= stall_cycles + 16'd1;

            if (flush && (flush_count != FLUSH_MAX))
                flush_count <= flush_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_exe_hazard_controller.sv
// Directed bench for exe_hazard_controller: a table of combinational vectors
// plus hand-written memory-wait, reset and saturation sequences.
module tb_exe_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       forward_en;
    logic [3:0] id_src1, id_src2;
    logic       id_two_src;
    logic [3:0] exe_src1, exe_src2;
    logic       exe_wb_en, exe_mem_r_en;
    logic [3:0] exe_dest;
    logic       branch_taken;
    logic       mem_wb_en;
    logic [3:0] mem_dest;
    logic       mem_req, mem_ready;
    logic       wb_wb_en;
    logic [3:0] wb_dest;
    logic [1:0] alu_src1_mux_sel, alu_src2_mux_sel;
    logic       freeze_front, bubble_exe, flush, freeze_all;
    logic [15:0] stall_cycles;
    logic [7:0]  flush_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exe_hazard_controller dut (
        .clk              (clk),
        .rst              (rst),
        .forward_en       (forward_en),
        .id_src1          (id_src1),
        .id_src2          (id_src2),
        .id_two_src       (id_two_src),
        .exe_src1         (exe_src1),
        .exe_src2         (exe_src2),
        .exe_wb_en        (exe_wb_en),
        .exe_mem_r_en     (exe_mem_r_en),
        .exe_dest         (exe_dest),
        .branch_taken     (branch_taken),
        .mem_wb_en        (mem_wb_en),
        .mem_dest         (mem_dest),
        .mem_req          (mem_req),
        .mem_ready        (mem_ready),
        .wb_wb_en         (wb_wb_en),
        .wb_dest          (wb_dest),
        .alu_src1_mux_sel (alu_src1_mux_sel),
        .alu_src2_mux_sel (alu_src2_mux_sel),
        .freeze_front     (freeze_front),
        .bubble_exe       (bubble_exe),
        .flush            (flush),
        .freeze_all       (freeze_all),
        .stall_cycles     (stall_cycles),
        .flush_count      (flush_count)
    );

    typedef struct {
        logic       fwd;
        logic [3:0] s1, s2;
        logic       two;
        logic [3:0] e1, e2;
        logic       ewb, eld;
        logic [3:0] edst;
        logic       br;
        logic       mwb;
        logic [3:0] mdst;
        logic       wwb;
        logic [3:0] wdst;
        logic [1:0] x_sel1, x_sel2;
        logic       x_ff, x_be, x_fl;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        forward_en = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
        exe_src1 = 0; exe_src2 = 0; exe_wb_en = 0; exe_mem_r_en = 0; exe_dest = 0;
        branch_taken = 0; mem_wb_en = 0; mem_dest = 0; mem_req = 0; mem_ready = 0;
        wb_wb_en = 0; wb_dest = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    task automatic apply_vec(input vec_t v);
        forward_en = v.fwd; id_src1 = v.s1; id_src2 = v.s2; id_two_src = v.two;
        exe_src1 = v.e1; exe_src2 = v.e2; exe_wb_en = v.ewb; exe_mem_r_en = v.eld;
        exe_dest = v.edst; branch_taken = v.br; mem_wb_en = v.mwb; mem_dest = v.mdst;
        wb_wb_en = v.wwb; wb_dest = v.wdst; mem_req = 0; mem_ready = 0;
    endtask

    initial begin
        //          fwd s1 s2 two e1 e2 ewb eld edst br mwb mdst wwb wdst  sel1   sel2  ff be fl
        vecs[0]  = '{1, 1, 2, 0,  3, 9, 0,  0,  12,  0, 1,  3,   1,  3,   2'b01, 2'b00, 0, 0, 0};
        vecs[1]  = '{1, 1, 2, 0,  3, 9, 0,  0,  12,  0, 0,  3,   1,  3,   2'b10, 2'b00, 0, 0, 0};
        vecs[2]  = '{0, 1, 2, 0,  3, 9, 0,  0,  12,  0, 1,  3,   1,  3,   2'b00, 2'b00, 0, 0, 0};
        vecs[3]  = '{1, 1, 2, 0,  8, 4, 0,  0,  12,  0, 1,  6,   1,  4,   2'b00, 2'b10, 0, 0, 0};
        vecs[4]  = '{1, 1, 2, 0,  6, 6, 0,  0,  12,  0, 1,  6,   1,  6,   2'b01, 2'b01, 0, 0, 0};
        vecs[5]  = '{1, 1, 5, 1,  8, 9, 1,  1,  5,   0, 0,  3,   0,  4,   2'b00, 2'b00, 1, 1, 0};
        vecs[6]  = '{1, 1, 5, 0,  8, 9, 1,  1,  5,   0, 0,  3,   0,  4,   2'b00, 2'b00, 0, 0, 0};
        vecs[7]  = '{1, 5, 2, 0,  8, 9, 1,  1,  5,   0, 0,  3,   0,  4,   2'b00, 2'b00, 1, 1, 0};
        vecs[8]  = '{1, 5, 2, 0,  8, 9, 1,  0,  5,   0, 0,  3,   0,  4,   2'b00, 2'b00, 0, 0, 0};
        vecs[9]  = '{0, 7, 2, 0,  8, 9, 0,  0,  12,  0, 1,  7,   0,  4,   2'b00, 2'b00, 1, 1, 0};
        vecs[10] = '{0, 7, 2, 0,  8, 9, 0,  0,  12,  1, 1,  7,   0,  4,   2'b00, 2'b00, 0, 0, 1};
        vecs[11] = '{0, 0, 2, 1,  8, 9, 1,  0,  2,   0, 0,  3,   0,  4,   2'b00, 2'b00, 1, 1, 0};
        vecs[12] = '{1, 0, 2, 0,  0, 9, 1,  1,  0,   0, 1,  0,   0,  4,   2'b01, 2'b00, 1, 1, 0};
        vecs[13] = '{1, 1, 2, 0,  8, 9, 0,  0,  12,  1, 0,  3,   0,  4,   2'b00, 2'b00, 0, 0, 1};

        rst = 1;
        idle_inputs();
        #2 rst = 0;
        #1;
        check("reset_stall_cycles", {16'd0, stall_cycles}, 32'd0);
        check("reset_flush_count", {24'd0, flush_count}, 32'd0);
        check("reset_freeze_all", {31'd0, freeze_all}, 32'd0);
        check("reset_flush", {31'd0, flush}, 32'd0);
        @(negedge clk);
        rst = 1;

        // Combinational vectors: mem_req stays low so the FSM remains in RUN.
        foreach (vecs[i]) begin
            @(negedge clk);
            apply_vec(vecs[i]);
            #1;
            check($sformatf("vec%0d", i),
                  {25'd0, alu_src1_mux_sel, alu_src2_mux_sel, freeze_front, bubble_exe, flush},
                  {25'd0, vecs[i].x_sel1, vecs[i].x_sel2, vecs[i].x_ff, vecs[i].x_be, vecs[i].x_fl});
        end

        // Memory wait of four cycles with a branch in the second one.
        do_reset();
        mem_req = 1; mem_ready = 0;
        // Hazard present during the wait must be masked by the freeze.
        forward_en = 1; exe_mem_r_en = 1; exe_dest = 5; id_src1 = 5;
        for (int i = 0; i < 4; i++) begin
            branch_taken = (i == 1);
            #1;
            check($sformatf("wait%0d_freeze_all", i), {31'd0, freeze_all}, 32'd1);
            check($sformatf("wait%0d_flush_ff", i), {30'd0, flush, freeze_front}, 32'd0);
            @(negedge clk);
        end
        branch_taken = 0; mem_ready = 1;
        #1;
        check("ready_freeze_all", {31'd0, freeze_all}, 32'd0);
        check("ready_flush", {31'd0, flush}, 32'd1);
        check("ready_freeze_front", {31'd0, freeze_front}, 32'd0);
        check("wait_stall_cycles", {16'd0, stall_cycles}, 32'd4);
        @(negedge clk);
        mem_req = 0; mem_ready = 0;
        #1;
        check("after_flush", {31'd0, flush}, 32'd0);
        check("after_freeze_front", {31'd0, freeze_front}, 32'd1);
        check("wait_flush_count", {24'd0, flush_count}, 32'd1);
        check("after_stall_cycles", {16'd0, stall_cycles}, 32'd4);

        // Reset in the middle of a wait with a flush pending.
        do_reset();
        mem_req = 1; mem_ready = 0; branch_taken = 1;
        repeat (2) @(negedge clk);
        branch_taken = 0; mem_req = 0;
        #1;
        check("pre_reset_freeze_all", {31'd0, freeze_all}, 32'd1);
        #2 rst = 0;
        #1;
        check("midwait_reset_freeze_all", {31'd0, freeze_all}, 32'd0);
        check("midwait_reset_stall", {16'd0, stall_cycles}, 32'd0);
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("post_reset%0d_flush_freeze", i), {30'd0, flush, freeze_all}, 32'd0);
            @(negedge clk);
        end
        check("post_reset_counters", {8'd0, stall_cycles, flush_count}, 32'd0);

        // Saturation of both counters.
        do_reset();
        mem_req = 1; mem_ready = 0;
        repeat (65535) @(negedge clk);
        check("stall_at_max", {16'd0, stall_cycles}, 32'h0000FFFF);
        repeat (70000 - 65535) @(negedge clk);
        check("stall_saturated", {16'd0, stall_cycles}, 32'h0000FFFF);
        mem_ready = 1;
        @(negedge clk);
        mem_req = 0; mem_ready = 0; branch_taken = 1;
        repeat (254) @(negedge clk);
        check("flush_count_254", {24'd0, flush_count}, 32'd254);
        repeat (300 - 254) @(negedge clk);
        check("flush_count_saturated", {24'd0, flush_count}, 32'h000000FF);
        check("stall_still_saturated", {16'd0, stall_cycles}, 32'h0000FFFF);
        branch_taken = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
